pipelined_datapath: RTL and testbench

// Second-generation processor datapath: register file, 8-op ALU, data memory and write-back mux.

---
 rtl/datapath_pkg.sv | 17 +
 rtl/dp_regfile.sv | 32 +++
 rtl/pipelined_datapath.sv | 112 +++++++++++
 tb/tb_pipelined_datapath.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types for the pipelined datapath: ALU opcode encoding and control widths.
package datapath_pkg;

  localparam int ALU_SEL_W = 3;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ZERO   = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_PASS_A = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_OR     = 3'd5,
    ALU_AND    = 3'd6,
    ALU_INC    = 3'd7
  } alu_op_e;

endpackage

// File: rtl/dp_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, optional hardwired R0.
module dp_regfile #(
  parameter  int DATA_W   = 16,
  parameter  int RF_DEPTH = 16,
  parameter  int ZERO_REG = 0,
  localparam int RA_W     = $clog2(RF_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [RA_W-1:0]   ra_addr,
  input  logic [RA_W-1:0]   rb_addr,
  output logic [DATA_W-1:0] ra,
  output logic [DATA_W-1:0] rb
);

  logic [RF_DEPTH-1:0][DATA_W-1:0] regs;

  // Reset has priority, so a write arriving with reset is lost.
  always_ff @(posedge clk) begin
    if (reset)
      regs <= '0;
    else if (we && !(ZERO_REG != 0 && w_addr == '0))
      regs[w_addr] <= w_data;
  end

  assign ra = (ZERO_REG != 0 && ra_addr == '0) ? '0 : regs[ra_addr];
  assign rb = (ZERO_REG != 0 && rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage (execute / write-back) datapath: RF with W->E forwarding, 8-op ALU, sync-read dmem.
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int RF_DEPTH = 16,
  parameter  int DM_DEPTH = 256,
  parameter  int ZERO_REG = 0,
  localparam int RA_W     = $clog2(RF_DEPTH),
  localparam int DA_W     = $clog2(DM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DA_W-1:0]      d_addr,
  input  logic                 d_wr,
  input  logic                 rf_s,
  input  logic                 rf_w_en,
  input  logic [RA_W-1:0]      rf_w_addr,
  input  logic [RA_W-1:0]      rf_ra_addr,
  input  logic [RA_W-1:0]      rf_rb_addr,
  input  logic [ALU_SEL_W-1:0] alu_sel,
  output logic [DATA_W-1:0]    ra_data,
  output logic [DATA_W-1:0]    rb_data,
  output logic [DATA_W-1:0]    alu_out,
  output logic                 wb_valid,
  output logic                 wb_en,
  output logic [RA_W-1:0]      wb_addr,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 flag_zero,
  output logic                 flag_neg
);

  // Field widths follow the module parameters, so the stage type is declared here.
  typedef struct packed {
    logic              valid;
    logic              w_en;
    logic [RA_W-1:0]   w_addr;
    logic              rf_s;
    logic [DATA_W-1:0] alu_r;
  } w_stage_t;

  w_stage_t          w_q;
  logic [DATA_W-1:0] rf_ra, rf_rb;
  logic [DATA_W-1:0] dmem [DM_DEPTH];
  logic [DATA_W-1:0] dmem_q;

  dp_regfile #(
    .DATA_W   (DATA_W),
    .RF_DEPTH (RF_DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en),
    .w_addr  (wb_addr),
    .w_data  (wb_data),
    .ra_addr (rf_ra_addr),
    .rb_addr (rf_rb_addr),
    .ra      (rf_ra),
    .rb      (rf_rb)
  );

  assign wb_valid = w_q.valid;
  assign wb_en    = w_q.w_en && !(ZERO_REG != 0 && w_q.w_addr == '0);
  assign wb_addr  = w_q.w_addr;
  assign wb_data  = w_q.rf_s ? dmem_q : w_q.alu_r;

  // wb_en is already false for a hardwired R0, so the regfile's zero read is never overridden.
  assign ra_data = (wb_en && wb_addr == rf_ra_addr) ? wb_data : rf_ra;
  assign rb_data = (wb_en && wb_addr == rf_rb_addr) ? wb_data : rf_rb;

  always_comb begin
    alu_out = '0;
    case (alu_op_e'(alu_sel))
      ALU_ZERO:   alu_out = '0;
      ALU_ADD:    alu_out = ra_data + rb_data;
      ALU_SUB:    alu_out = ra_data - rb_data;
      ALU_PASS_A: alu_out = ra_data;
      ALU_XOR:    alu_out = ra_data ^ rb_data;
      ALU_OR:     alu_out = ra_data | rb_data;
      ALU_AND:    alu_out = ra_data & rb_data;
      ALU_INC:    alu_out = ra_data + DATA_W'(1);
    endcase
  end

  // Read-before-write: a load at the same address as a same-cycle store sees the old word.
  always_ff @(posedge clk) begin
    if (in_valid && d_wr && !reset)
      dmem[d_addr] <= ra_data;
    dmem_q <= dmem[d_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q       <= '0;
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
    end else begin
      w_q.valid  <= in_valid;
      w_q.w_en   <= in_valid & rf_w_en;
      w_q.w_addr <= rf_w_addr;
      w_q.rf_s   <= rf_s;
      w_q.alu_r  <= alu_out;
      if (in_valid && !rf_s) begin
        flag_zero <= (alu_out == '0);
        flag_neg  <= alu_out[DATA_W-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench with an architectural model and a write-back scoreboard for pipelined_datapath.
module tb_pipelined_datapath;
  localparam int DW = 16, RAW = 4, DAW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1, in_valid = 1'b0, d_wr = 1'b0, rf_s = 1'b0, rf_w_en = 1'b0;
  logic [DAW-1:0] d_addr = '0;
  logic [RAW-1:0] rf_w_addr = '0, rf_ra_addr = '0, rf_rb_addr = '0;
  logic [2:0]     alu_sel = '0;

  logic [DW-1:0]  ra_data0, rb_data0, alu_out0, wb_data0, ra_data1, rb_data1, alu_out1, wb_data1;
  logic           wb_valid0, wb_en0, flag_zero0, flag_neg0, wb_valid1, wb_en1, flag_zero1, flag_neg1;
  logic [RAW-1:0] wb_addr0, wb_addr1;

  pipelined_datapath #(.DATA_W(DW), .RF_DEPTH(16), .DM_DEPTH(256), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .d_addr(d_addr), .d_wr(d_wr), .rf_s(rf_s),
    .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .alu_sel(alu_sel), .ra_data(ra_data0), .rb_data(rb_data0), .alu_out(alu_out0),
    .wb_valid(wb_valid0), .wb_en(wb_en0), .wb_addr(wb_addr0), .wb_data(wb_data0),
    .flag_zero(flag_zero0), .flag_neg(flag_neg0));

  pipelined_datapath #(.DATA_W(DW), .RF_DEPTH(16), .DM_DEPTH(256), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .d_addr(d_addr), .d_wr(d_wr), .rf_s(rf_s),
    .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .alu_sel(alu_sel), .ra_data(ra_data1), .rb_data(rb_data1), .alu_out(alu_out1),
    .wb_valid(wb_valid1), .wb_en(wb_en1), .wb_addr(wb_addr1), .wb_data(wb_data1),
    .flag_zero(flag_zero1), .flag_neg(flag_neg1));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [RAW-1:0] addr;
    logic           en;
    logic [DW-1:0]  data;
  } exp_t;
  exp_t sbq[$];

  // Architectural model: ops retire in order, so the model is always up to date at issue.
  logic [DW-1:0] mrf [16];
  logic [DW-1:0] mdm [256];
  logic          mz, mn;

  function automatic logic [DW-1:0] alu_m(input logic [2:0] sel, input logic [DW-1:0] a, b);
    case (sel)
      3'd0: return '0;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a;
      3'd4: return a ^ b;
      3'd5: return a | b;
      3'd6: return a & b;
      default: return a + 16'd1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    mz = 1'b0;
    mn = 1'b0;
  endtask

  always @(negedge clk) begin
    if (wb_valid0 === 1'b1) begin
      if (sbq.size() == 0) chk("sb_unexpected_wb", 32'(wb_valid0), 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_wb_en",   32'(wb_en0),   32'(e.en));
        chk("sb_wb_addr", 32'(wb_addr0), 32'(e.addr));
        chk("sb_wb_data", 32'(wb_data0), 32'(e.data));
      end
    end
  end

  task automatic op(input logic [2:0] sel, input logic [RAW-1:0] ra, rb, w,
                    input logic wen, rfs, dwr, input logic [DAW-1:0] da);
    logic [DW-1:0] a, b, r;
    exp_t e;
    in_valid = 1'b1; alu_sel = sel; rf_ra_addr = ra; rf_rb_addr = rb; rf_w_addr = w;
    rf_w_en = wen; rf_s = rfs; d_wr = dwr; d_addr = da;
    a = mrf[ra]; b = mrf[rb]; r = alu_m(sel, a, b);
    e.addr = w; e.en = wen; e.data = rfs ? mdm[da] : r;
    sbq.push_back(e);
    if (dwr) mdm[da] = a;
    if (wen) mrf[w] = e.data;
    if (!rfs) begin mz = (r == '0); mn = r[DW-1]; end
    #2;
    chk("ra_data", 32'(ra_data0), 32'(a));
    chk("rb_data", 32'(rb_data0), 32'(b));
    chk("alu_out", 32'(alu_out0), 32'(r));
    @(posedge clk); #1;
    chk("flag_zero", 32'(flag_zero0), 32'(mz));
    chk("flag_neg",  32'(flag_neg0),  32'(mn));
  endtask

  task automatic idle();
    in_valid = 1'b0; d_wr = 1'b1; rf_w_en = 1'b1; rf_s = 1'b0;  // d_wr/rf_w_en must be ignored
    @(posedge clk); #1;
    d_wr = 1'b0; rf_w_en = 1'b0;
  endtask

  task automatic alu_op(input int sel, ra, rb, w);
    op(3'(sel), 4'(ra), 4'(rb), 4'(w), 1'b1, 1'b0, 1'b0, 8'd0);
  endtask
  task automatic store(input int ra, da);
    op(3'd0, 4'(ra), 4'(ra), 4'd0, 1'b0, 1'b0, 1'b1, 8'(da));
  endtask
  task automatic load(input int da, w);
    op(3'd0, 4'd0, 4'd0, 4'(w), 1'b1, 1'b1, 1'b0, 8'(da));
  endtask

  // Build a constant with back-to-back doubling/increment ops (exercises forwarding).
  task automatic load_const(input int r, input logic [DW-1:0] v);
    alu_op(0, r, r, r);
    for (int i = DW - 1; i >= 0; i--) begin
      alu_op(1, r, r, r);
      if (v[i]) alu_op(7, r, r, r);
    end
  endtask

  logic [DW-1:0] sw [8];

  initial begin
    sw = '{16'h0000, 16'h0000, 16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'h0001, 16'h0000};
    for (int i = 0; i < 256; i++) mdm[i] = 'x;
    model_reset();

    // 1. reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf_ra_addr = 4'(i); rf_rb_addr = 4'(15 - i);
      #1;
      chk("rst_ra", 32'(ra_data0), 32'd0);
      chk("rst_rb", 32'(rb_data0), 32'd0);
    end
    chk("rst_wb_valid", 32'(wb_valid0), 32'd0);
    chk("rst_fz", 32'(flag_zero0), 32'd0);
    chk("rst_fn", 32'(flag_neg0), 32'd0);
    @(posedge clk); #1;

    // 2. load followed by dependent use
    load_const(11, 16'd8634);
    store(11, 27);
    load(27, 1);
    alu_op(1, 1, 1, 2);
    chk("load_use", 32'(wb_data0), 32'd17268);

    // 3. store then load, and same-cycle load+store
    load_const(3, 16'hA04E);
    store(3, 42);
    load(42, 4);
    idle();
    rf_ra_addr = 4'd4; #1;
    chk("store_load_r4", 32'(ra_data0), 32'hA04E);
    load_const(9, 16'd29100);
    store(9, 60);
    op(3'd0, 4'd3, 4'd3, 4'd10, 1'b1, 1'b1, 1'b1, 8'd60);
    chk("rdw_old", 32'(wb_data0), 32'd29100);
    load(60, 12);
    chk("rdw_new", 32'(wb_data0), 32'hA04E);

    // 4. ALU sweep
    load_const(5, 16'hFFFF);
    load_const(6, 16'h0001);
    for (int s = 0; s < 8; s++) begin
      alu_op(s, 5, 6, 7);
      chk("sweep_res", 32'(wb_data0), 32'(sw[s]));
      chk("sweep_fz", 32'(flag_zero0), 32'(sw[s] == '0));
      chk("sweep_fn", 32'(flag_neg0), 32'(sw[s][DW-1]));
    end

    // 5. R0 writes with and without the hardwired zero
    load_const(0, 16'h1234);
    chk("z1_wb_en", 32'(wb_en1), 32'd0);
    chk("z0_wb_en", 32'(wb_en0), 32'd1);
    idle();
    rf_ra_addr = 4'd0; #1;
    chk("z0_r0", 32'(ra_data0), 32'h1234);
    chk("z1_r0", 32'(ra_data1), 32'd0);

    // 6. reset while an op is in W
    alu_op(3, 5, 5, 8);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_wb_valid", 32'(wb_valid0), 32'd0);
    reset = 1'b0;
    model_reset();
    rf_ra_addr = 4'd8; #1;
    chk("rst_mid_r8", 32'(ra_data0), 32'd0);
    chk("rst_mid_fz", 32'(flag_zero0), 32'd0);
    alu_op(7, 8, 8, 8);

    idle();
    idle();
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
